// File: rtl/cpu_run_ctrl_if.sv
// Board-side signal bundle for the CPU run-control block.
// The master side drives the switches, the button and the CPU status.
// The slave side (cpu_run_ctrl) drives the clock enable and the display outputs.
interface cpu_run_ctrl_if #(
    parameter int unsigned PC_W = 32
) ();
    logic            choose;
    logic            run_sw;
    logic            step_btn;
    logic            halt_in;
    logic            bp_en;
    logic [PC_W-1:0] bp_addr;
    logic [PC_W-1:0] pc;
    logic            cpu_ce;
    logic [1:0]      state;
    logic            halted;
    logic [31:0]     cycle_cnt;
    logic            ce_led;

    modport master (
        output choose, run_sw, step_btn, halt_in, bp_en, bp_addr, pc,
        input  cpu_ce, state, halted, cycle_cnt, ce_led
    );

    modport slave (
        input  choose, run_sw, step_btn, halt_in, bp_en, bp_addr, pc,
        output cpu_ce, state, halted, cycle_cnt, ce_led
    );
endinterface

// File: rtl/cpu_run_ctrl.sv
// CPU run-control: free-run at a fast or slow rate, single-step from a debounced
// button, and halt on a CPU request or a PC breakpoint. Emits a registered,
// one-cycle clock-enable pulse per CPU cycle and counts the pulses.
module cpu_run_ctrl #(
    parameter int unsigned FAST_DIV   = 31,
    parameter int unsigned SLOW_DIV   = 2500000,
    parameter int unsigned DEB_CYCLES = 1000000,
    parameter int unsigned PC_W       = 32
) (
    input logic           clk_in,
    input logic           rst_n,
    cpu_run_ctrl_if.slave bus_io
);
    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StRun  = 2'b01,
        StStep = 2'b10,
        StHalt = 2'b11
    } state_e;

    state_e          state_q, state_d;
    logic            ret_halt_q, ret_halt_d;
    logic            bp_mask_q, bp_mask_d;
    logic            cpu_ce_q, cpu_ce_d;
    logic            halted_q, halted_d;
    logic [31:0]     cycle_cnt_q, cycle_cnt_d;
    logic            ce_led_q, ce_led_d;
    logic [31:0]     tick_cnt_q, tick_cnt_d;
    logic            choose_q;
    logic            sync1_q, sync2_q;
    logic            deb_q, deb_d;
    logic [31:0]     deb_cnt_q, deb_cnt_d;
    logic            step_ev_q, step_ev_d;
    logic [31:0]     div;
    logic            tick;
    logic            bp_hit;
    logic [PC_W-1:0] pc, bp_addr;

    assign pc      = bus_io.pc;
    assign bp_addr = bus_io.bp_addr;
    assign bp_hit  = bus_io.bp_en & (pc == bp_addr) & ~bp_mask_q;

    // Rate divider: counts only in RUN and restarts whenever the rate select changes.
    always_comb begin
        div        = bus_io.choose ? 32'(FAST_DIV) : 32'(SLOW_DIV);
        tick       = 1'b0;
        tick_cnt_d = '0;
        if (state_q == StRun && bus_io.choose == choose_q) begin
            if (tick_cnt_q == div - 32'd1) begin
                tick = 1'b1;
            end else begin
                tick_cnt_d = tick_cnt_q + 32'd1;
            end
        end
    end

    // Debouncer: adopt the synchronized level after DEB_CYCLES consecutive differing samples.
    always_comb begin
        deb_d     = deb_q;
        deb_cnt_d = '0;
        step_ev_d = 1'b0;
        if (sync2_q != deb_q) begin
            if (deb_cnt_q >= 32'(DEB_CYCLES - 1)) begin
                deb_d     = sync2_q;
                step_ev_d = sync2_q;
            end else begin
                deb_cnt_d = deb_cnt_q + 32'd1;
            end
        end
    end

    // Run-control FSM: next state, breakpoint mask and the clock-enable request.
    always_comb begin
        state_d    = state_q;
        ret_halt_d = ret_halt_q;
        bp_mask_d  = bp_mask_q;
        cpu_ce_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus_io.run_sw) begin
                    state_d   = StRun;
                    bp_mask_d = 1'b1;
                end else if (step_ev_q) begin
                    state_d    = StStep;
                    ret_halt_d = 1'b0;
                    cpu_ce_d   = 1'b1;
                end
            end
            StRun: begin
                // Any exit swallows a coinciding tick.
                if (!bus_io.run_sw) begin
                    state_d = StIdle;
                end else if (bus_io.halt_in || bp_hit) begin
                    state_d = StHalt;
                end else if (tick && !cpu_ce_q) begin
                    cpu_ce_d  = 1'b1;
                    bp_mask_d = 1'b0;
                end
            end
            StHalt: begin
                if (!bus_io.run_sw) begin
                    state_d = StIdle;
                end else if (step_ev_q && !bus_io.halt_in) begin
                    state_d    = StStep;
                    ret_halt_d = 1'b1;
                    bp_mask_d  = 1'b1;
                    cpu_ce_d   = 1'b1;
                end
            end
            StStep: begin
                state_d   = ret_halt_q ? StHalt : StIdle;
                bp_mask_d = 1'b0;
            end
        endcase
        halted_d    = (state_d == StHalt);
        cycle_cnt_d = cycle_cnt_q + 32'(cpu_ce_d);
        ce_led_d    = ce_led_q ^ cpu_ce_d;
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            ret_halt_q  <= 1'b0;
            bp_mask_q   <= 1'b0;
            cpu_ce_q    <= 1'b0;
            halted_q    <= 1'b0;
            cycle_cnt_q <= '0;
            ce_led_q    <= 1'b0;
            tick_cnt_q  <= '0;
            choose_q    <= 1'b0;
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            deb_q       <= 1'b0;
            deb_cnt_q   <= '0;
            step_ev_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ret_halt_q  <= ret_halt_d;
            bp_mask_q   <= bp_mask_d;
            cpu_ce_q    <= cpu_ce_d;
            halted_q    <= halted_d;
            cycle_cnt_q <= cycle_cnt_d;
            ce_led_q    <= ce_led_d;
            tick_cnt_q  <= tick_cnt_d;
            choose_q    <= bus_io.choose;
            sync1_q     <= bus_io.step_btn;
            sync2_q     <= sync1_q;
            deb_q       <= deb_d;
            deb_cnt_q   <= deb_cnt_d;
            step_ev_q   <= step_ev_d;
        end
    end

    assign bus_io.cpu_ce    = cpu_ce_q;
    assign bus_io.state     = state_q;
    assign bus_io.halted    = halted_q;
    assign bus_io.cycle_cnt = cycle_cnt_q;
    assign bus_io.ce_led    = ce_led_q;
endmodule
